// File: rtl/uart_rx_fifo.sv
// UART receiver (8 data bits, optional parity, 1 stop) feeding a small
// first-word-fall-through byte FIFO read by the CPU I/O controller.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int FIFO_ADDR_W  = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rx,
  input  logic                   rd_en,
  output logic [7:0]             rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [FIFO_ADDR_W:0]   count,
  output logic                   frame_err,
  output logic                   parity_err,
  output logic                   overrun,
  output logic [2:0]             dbg_state_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int DEPTH = 1 << FIFO_ADDR_W;
  localparam logic [CNT_W-1:0]     HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]     FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_ADDR_W:0] DEPTH_C = (FIFO_ADDR_W + 1)'(DEPTH);
  localparam logic                 ODD_C   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_HIGH = 3'd5
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2:0]             bit_q, bit_d;
  logic [7:0]             shift_q, shift_d;
  logic                   par_bad_q, par_bad_d;
  logic                   meta_q, rxs_q;
  logic                   frame_err_q, frame_err_d;
  logic                   parity_err_q, parity_err_d;
  logic                   overrun_q, overrun_d;
  logic                   push_req;
  logic [FIFO_ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_ADDR_W:0]   count_q, count_d;
  logic [7:0]             mem_q [DEPTH];
  logic                   do_push, do_pop;

  // Receiver: the counter restarts on every state change, so each sample
  // lands at mid-bit once the start bit has been confirmed at its centre.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CNT_W'(1);
    bit_d        = bit_q;
    shift_d      = shift_q;
    par_bad_d    = par_bad_q;
    push_req     = 1'b0;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rxs_q) begin
          state_d   = S_START;
          par_bad_d = 1'b0;
        end
      end
      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rxs_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rxs_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (cnt_q == FULL_M1) begin
          cnt_d     = '0;
          par_bad_d = ((^shift_q) ^ rxs_q) != ODD_C;
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (!rxs_q) begin
            frame_err_d = 1'b1;
            state_d     = S_WAIT_HIGH;
          end else if (par_bad_q) begin
            parity_err_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            push_req = 1'b1;
            state_d  = S_IDLE;
          end
        end
      end
      S_WAIT_HIGH: begin
        cnt_d = '0;
        if (rxs_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      par_bad_q    <= 1'b0;
      meta_q       <= 1'b1;
      rxs_q        <= 1'b1;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      par_bad_q    <= par_bad_d;
      meta_q       <= rx;
      rxs_q        <= meta_q;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
    end
  end

  // A push into a full FIFO still succeeds when a pop frees the slot
  // on the same edge; otherwise the byte is dropped and flagged.
  always_comb begin
    do_pop    = rd_en && (count_q != '0);
    do_push   = push_req && ((count_q != DEPTH_C) || do_pop);
    overrun_d = push_req && (count_q == DEPTH_C) && !do_pop;
    wr_ptr_d  = do_push ? wr_ptr_q + FIFO_ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d  = do_pop ? rd_ptr_q + FIFO_ADDR_W'(1) : rd_ptr_q;
    count_d   = count_q + {{FIFO_ADDR_W{1'b0}}, do_push}
                        - {{FIFO_ADDR_W{1'b0}}, do_pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
      if (do_push) mem_q[wr_ptr_q] <= shift_q;
    end
  end

  assign rd_data     = mem_q[rd_ptr_q];
  assign empty       = (count_q == '0);
  assign full        = (count_q == DEPTH_C);
  assign count       = count_q;
  assign frame_err   = frame_err_q;
  assign parity_err  = parity_err_q;
  assign overrun     = overrun_q;
  assign dbg_state_o = state_q;

endmodule
